i2s_dac_serializer: RTL

//  Transmit end of the codec sample path: accepts stereo samples from the per-channel

---
 rtl/audio_pkg.sv | 14 +
 rtl/sync_edge_detect.sv | 37 +++
 rtl/i2s_dac_serializer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the codec sample path.
package audio_pkg;

    localparam int AUDIO_DATA_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT
    } dac_state_t;

    typedef logic [AUDIO_DATA_WIDTH-1:0] sample_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchronizer for an async level, with one-clk rise/fall pulses.
module sync_edge_detect
    import audio_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync = sync_q[STAGES-1];
    assign rise = sync & ~prev_q;
    assign fall = ~sync & prev_q;

endmodule

// File: rtl/i2s_dac_serializer.sv
// Stereo I2S transmitter: one-frame holding register feeding two MSB-first shift registers,
// timed by the codec-driven BCLK/DACLRCK after synchronization into clk (clk >= 8x BCLK).
//
// state | meaning
// IDLE  | waiting for the first left-channel start; dacdat held 0
// LEFT  | shifting the left sample
// RIGHT | shifting the right sample
module i2s_dac_serializer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH  = AUDIO_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    output logic                  write_ready,
    input  logic [DATA_WIDTH-1:0] writedata_left,
    input  logic [DATA_WIDTH-1:0] writedata_right,
    input  logic                  aud_bclk,
    input  logic                  aud_daclrck,
    output logic                  aud_dacdat,
    output logic                  underrun
);

    localparam logic [4:0] BITS = 5'(DATA_WIDTH);

    logic bclk_fall;
    logic bclk_sync;
    logic bclk_rise;

    logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
    logic                   lrck_s;
    logic                   lrck_prev_q, lrck_prev_d;

    dac_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
    logic [4:0]            bitcnt_q, bitcnt_d;
    logic                  dacdat_q, dacdat_d;
    logic                  underrun_q, underrun_d;

    logic ch_start, left_start, right_start, write_accept;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk  (clk),
        .rst  (reset),
        .din  (aud_bclk),
        .sync (bclk_sync),
        .rise (bclk_rise),
        .fall (bclk_fall)
    );

    assign lrck_s       = lrck_sync_q[SYNC_STAGES-1];
    assign ch_start     = bclk_fall & (lrck_s ^ lrck_prev_q);
    assign left_start   = ch_start & ~lrck_s;
    assign right_start  = ch_start & lrck_s;
    assign write_accept = write & ~hold_full_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (left_start)  state_d = LEFT;
            LEFT:    if (right_start) state_d = RIGHT;
            RIGHT:   if (left_start)  state_d = LEFT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], aud_daclrck};
        lrck_prev_d = bclk_fall ? lrck_s : lrck_prev_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        hold_full_d = hold_full_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        bitcnt_d    = bitcnt_q;
        dacdat_d    = dacdat_q;
        underrun_d  = 1'b0;

        // Frame load happens first so a same-cycle write into an empty holding reg survives.
        if (left_start) begin
            shift_l_d   = hold_full_q ? hold_l_q : '0;
            shift_r_d   = hold_full_q ? hold_r_q : '0;
            hold_full_d = 1'b0;
            underrun_d  = ~hold_full_q;
        end
        if (write_accept) begin
            hold_l_d    = writedata_left;
            hold_r_d    = writedata_right;
            hold_full_d = 1'b1;
        end

        if (bclk_fall) begin
            if (left_start || (right_start && state_q == LEFT)) begin
                bitcnt_d = '0;
                dacdat_d = 1'b0;
            end else if (state_q != IDLE && bitcnt_q < BITS) begin
                bitcnt_d = bitcnt_q + 5'd1;
                if (state_q == LEFT) begin
                    dacdat_d  = shift_l_q[DATA_WIDTH-1];
                    shift_l_d = shift_l_q << 1;
                end else begin
                    dacdat_d  = shift_r_q[DATA_WIDTH-1];
                    shift_r_d = shift_r_q << 1;
                end
            end else begin
                dacdat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lrck_sync_q <= '0;
            lrck_prev_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
            shift_l_q   <= '0;
            shift_r_q   <= '0;
            bitcnt_q    <= '0;
            dacdat_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            lrck_sync_q <= lrck_sync_d;
            lrck_prev_q <= lrck_prev_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            hold_full_q <= hold_full_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            bitcnt_q    <= bitcnt_d;
            dacdat_q    <= dacdat_d;
            underrun_q  <= underrun_d;
        end
    end

    assign write_ready = ~hold_full_q;
    assign aud_dacdat  = dacdat_q;
    assign underrun    = underrun_q;

endmodule
